// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data bus, lane steering and timeout
//
// Executes lb/lh/lw/lbu/lhu/sb/sh/sw against a word-wide memory bus and
// holds the pipeline until the access completes.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite   load / store request (both high -> store)
//   opcode[5:0]         [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
//   addr[31:0]          byte address
//   wdata[31:0]         right-justified store data
//   rdata[31:0]         extended load result, valid in the DONE cycle and held after
//   Stall               combinational pipeline hold
//   AddrErr, BusErr     one-cycle error pulses (misaligned / bus timeout)
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   registered bus request
//   bus_ack, bus_rdata  bus completion and read data

module mem_access_unit #(
    parameter int TIMEOUT    = 16,
    parameter bit ENDIAN_BIG = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;

    logic           req;
    logic           is_byte;
    logic           is_half;
    logic           misaligned;
    logic           start;
    logic           timeout_hit;
    logic [1:0]     lane;
    logic [3:0]     be_nx;
    logic [31:0]    wd_nx;

    // Load shape latched at the start of the access; the request inputs may
    // change while the pipeline is stalled.
    logic           ld_unsigned;
    logic           ld_byte;
    logic           ld_half;
    logic [1:0]     ld_lane;
    logic [7:0]     ld_b;
    logic [15:0]    ld_h;
    logic [31:0]    ld_val;

    logic           unused_opcode;
    assign unused_opcode = ^opcode[5:3];

    assign req     = MemRead | MemWrite;
    assign is_byte = (opcode[1:0] == 2'b00);
    assign is_half = (opcode[1:0] == 2'b01);
    // Size 10 falls through to word handling everywhere below.
    assign misaligned = (is_half & addr[0]) |
                        (~is_byte & ~is_half & (addr[1:0] != 2'b00));

    // Lane of the lowest enabled byte. Big-endian mirrors the lane within the
    // word, so a half at offset 0 lives in lanes 3:2.
    always_comb begin
        lane = 2'b00;
        if (is_byte)
            lane = ENDIAN_BIG ? ~addr[1:0] : addr[1:0];
        else if (is_half)
            lane = ENDIAN_BIG ? {~addr[1], 1'b0} : {addr[1], 1'b0};
    end

    always_comb begin
        be_nx = 4'b1111;
        wd_nx = wdata;
        if (is_byte) begin
            be_nx = 4'b0001 << lane;
            wd_nx = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_nx = 4'b0011 << lane;
            wd_nx = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        ld_b = bus_rdata[7:0];
        case (ld_lane)
            2'd0: ld_b = bus_rdata[7:0];
            2'd1: ld_b = bus_rdata[15:8];
            2'd2: ld_b = bus_rdata[23:16];
            2'd3: ld_b = bus_rdata[31:24];
            default: ld_b = bus_rdata[7:0];
        endcase
        ld_h = ld_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        if (ld_byte)
            ld_val = {{24{~ld_unsigned & ld_b[7]}}, ld_b};
        else if (ld_half)
            ld_val = {{16{~ld_unsigned & ld_h[15]}}, ld_h};
        else
            ld_val = bus_rdata;
    end

    // cnt holds the number of completed BUSY cycles, so the compare fires in
    // the TIMEOUT-th BUSY cycle without an ack.
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        Stall    = 1'b0;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !misaligned) begin
                    start    = 1'b1;
                    Stall    = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (bus_ack || timeout_hit)
                    state_nx = DONE;
            end
            DONE: begin
                // Request still shows the instruction just completed.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rdata       <= '0;
            AddrErr     <= 1'b0;
            BusErr      <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            ld_unsigned <= 1'b0;
            ld_byte     <= 1'b0;
            ld_half     <= 1'b0;
            ld_lane     <= 2'b00;
        end else begin
            state   <= state_nx;
            AddrErr <= (state == IDLE) && req && misaligned;
            BusErr  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        bus_req     <= 1'b1;
                        bus_we      <= MemWrite;
                        bus_addr    <= {addr[31:2], 2'b00};
                        bus_be      <= be_nx;
                        bus_wdata   <= wd_nx;
                        ld_unsigned <= opcode[2];
                        ld_byte     <= is_byte;
                        ld_half     <= is_half;
                        ld_lane     <= lane;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            rdata <= ld_val;
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        rdata   <= '0;
                        BusErr  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        Stall;
    logic        AddrErr;
    logic        BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        chk_rd;
        logic        berr;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    mem_access_unit #(.TIMEOUT(16), .ENDIAN_BIG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .opcode(opcode),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rdata"},     rdata,     32'h0);
        chk({tag, "_stall"},     32'(Stall),   32'h0);
        chk({tag, "_addrerr"},   32'(AddrErr), 32'h0);
        chk({tag, "_buserr"},    32'(BusErr),  32'h0);
        chk({tag, "_bus_req"},   32'(bus_req), 32'h0);
        chk({tag, "_bus_we"},    32'(bus_we),  32'h0);
        chk({tag, "_bus_addr"},  bus_addr,  32'h0);
        chk({tag, "_bus_be"},    32'(bus_be),  32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    endtask

    // Issue one access and act as the bus slave: ack in BUSY cycle ack_at
    // (0 = never). The expected outcome is already at the head of exp_q.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at,
                             input logic [31:0] brd);
        int   stalls;
        int   busy;
        bit   fin;
        exp_t e;
        stalls = 0;
        busy   = 0;
        fin    = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; opcode = op; addr = a; wdata = wd;
        #1 if (Stall) stalls++;
        for (int c = 0; c < 64 && !fin; c++) begin
            @(negedge clk);
            if (bus_req) begin
                busy++;
                if (busy == 1) begin
                    e = exp_q[0];
                    chk({tag, "_bus_addr"}, bus_addr, e.addr);
                    chk({tag, "_bus_be"}, 32'(bus_be), 32'(e.be));
                    chk({tag, "_bus_we"}, 32'(bus_we), 32'(e.we));
                    if (e.we) chk({tag, "_bus_wdata"}, bus_wdata, e.wdata);
                end
                bus_ack   = (busy == ack_at);
                bus_rdata = brd;
                #1 if (Stall) stalls++;
            end else begin
                fin = 1;
                MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
                e = exp_q.pop_front();
                #1;
                chk({tag, "_done_stall"}, 32'(Stall), 32'h0);
                chk({tag, "_stall_cycles"}, 32'(stalls), 32'(e.stalls));
                chk({tag, "_buserr"}, 32'(BusErr), 32'(e.berr));
                if (e.chk_rd) chk({tag, "_rdata"}, rdata, e.rdata);
            end
        end
        if (!fin) begin
            chk({tag, "_completion_bound"}, 32'h0, 32'h1);
            MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic do_misaligned(input string tag, input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] rd_before);
        bit seen_req;
        seen_req = 0;
        @(negedge clk);
        MemRead = 1'b1; opcode = op; addr = a;
        #1 chk({tag, "_stall"}, 32'(Stall), 32'h0);
        @(negedge clk);
        MemRead = 1'b0;
        if (bus_req) seen_req = 1;
        chk({tag, "_addrerr_pulse"}, 32'(AddrErr), 32'h1);
        chk({tag, "_rdata_kept"}, rdata, rd_before);
        @(negedge clk);
        if (bus_req) seen_req = 1;
        chk({tag, "_addrerr_clear"}, 32'(AddrErr), 32'h0);
        chk({tag, "_no_bus_req"}, 32'(seen_req), 32'h0);
    endtask

    initial begin
        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_values("post_reset_idle");

        exp_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3});
        do_access("lw_100", 1'b1, 1'b0, OP_LW, 32'h100, 32'h0, 2, 32'hDEADBEEF);

        exp_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 2});
        do_access("lb_103", 1'b1, 1'b0, OP_LB, 32'h103, 32'h0, 1, 32'h80123456);

        exp_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0, 32'h00000080, 1'b1, 1'b0, 2});
        do_access("lbu_103", 1'b1, 1'b0, OP_LBU, 32'h103, 32'h0, 1, 32'h80123456);

        exp_q.push_back('{32'h100, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 2});
        do_access("sh_102", 1'b0, 1'b1, OP_SH, 32'h102, 32'h1234ABCD, 1, 32'h0);

        exp_q.push_back('{32'h000, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 2});
        do_access("lh_002", 1'b1, 1'b0, OP_LH, 32'h002, 32'h0, 1, 32'h80017FFF);

        exp_q.push_back('{32'h000, 4'b0011, 1'b0, 32'h0, 32'h0000F00D, 1'b1, 1'b0, 2});
        do_access("lhu_000", 1'b1, 1'b0, OP_LHU, 32'h000, 32'h0, 1, 32'h1234F00D);

        exp_q.push_back('{32'h200, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 4});
        do_access("sb_201", 1'b0, 1'b1, OP_SB, 32'h201, 32'h000000A5, 3, 32'h0);

        // Both strobes high: the store must win.
        exp_q.push_back('{32'h300, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2});
        do_access("rw_sw_300", 1'b1, 1'b1, OP_SW, 32'h300, 32'hCAFEF00D, 1, 32'h0);

        do_misaligned("lw_101", OP_LW, 32'h101, 32'h0000F00D);
        do_misaligned("lh_003", OP_LH, 32'h003, 32'h0000F00D);

        // A stray ack while idle must not start anything.
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_ack_bus_req", 32'(bus_req), 32'h0);
        chk("stray_ack_rdata", rdata, 32'h0000F00D);

        exp_q.push_back('{32'h400, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 17});
        do_access("lw_timeout", 1'b1, 1'b0, OP_LW, 32'h400, 32'h0, 0, 32'h55555555);
        @(negedge clk);
        chk("timeout_buserr_clear", 32'(BusErr), 32'h0);
        chk("timeout_idle_bus_req", 32'(bus_req), 32'h0);

        // Reset while BUSY drops the request at once.
        @(negedge clk);
        MemRead = 1'b1; opcode = OP_LW; addr = 32'h500;
        @(negedge clk);
        chk("pre_reset_busy_req", 32'(bus_req), 32'h1);
        rst_n = 1'b0; MemRead = 1'b0;
        #1 chk("reset_busy_bus_req", 32'(bus_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_values("post_busy_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
